alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational datapath ALU.
- Adds:
  - a WIDTH-generic datapath;
  - an architectural NZCV flag register;
  - ARM-style condition evaluation against the stored flags;
  - a multi-cycle shift-add multiplier;
  - valid/ready flow control on both sides.
- Sits between decode/register-read and writeback in the core pipeline.

Parameters:
- WIDTH, 32, datapath width in bits; must be a power of two and at least 8.
- SHW, $clog2(WIDTH), width of the shift-amount field (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block can accept an operation this cycle.
- opcode  in  4  operation select.
- cond  in  4  condition code.
- s  in  1  set-flags request.
- sh_ctl  in  2  operand-B pre-shift: 00 none, 01 LSR, 10 LSL, 11 ROR.
- sh_amt  in  SHW  shift amount, 0..WIDTH-1.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- imm  in  WIDTH/2  immediate for MOVI.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  registered result.
- executed  out  1  condition passed for the presented result.
- flags  out  4  registered {N,Z,C,V}.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, executed=0, flags=4'b0000, multiplier registers cleared. Asserting reset mid-multiply aborts the operation with no output.
- Accept: transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready), so back-to-back single-cycle ops sustain 1 op/clk.
- Operand B: b' = shift(op_b, sh_ctl, sh_amt); sh_amt=0 passes op_b unchanged. All ops use b'.
- Condition: evaluated at accept on the current flags register.
  - 0000 AL
  - 0001 EQ: Z
  - 0010 NE: !Z
  - 0011 GT: !Z && N==V
  - 0100 LT: N!=V
  - 0101 GE: N==V
  - 0110 LE: Z || N!=V
  - 0111 HI: C && !Z
  - 1000 LO: !C
  - 1001 HS: C
  - 1010-1111: never
- Condition fails: result=0, executed=0, flags unchanged, 1-cycle latency, even for MUL.
- Opcodes:
  - 0000 ADD: a+b'. C = carry out; V = signed overflow.
  - 0001 SUB: a-b'. C = no-borrow (a>=b' unsigned); V = signed overflow.
  - 0010 MUL: low WIDTH bits of a*b'. C=0, V=0.
  - 0011 OR, 0100 AND, 0101 XOR: C and V preserved.
  - 0110 MOVI: result = zero-extended imm. C and V preserved.
  - 0111 MOV: result = a. C and V preserved.
  - 1011 CMP: computes SUB; result=a-b'; flags always updated regardless of s.
  - All other opcodes: result=0, executed=1, flags unchanged.
- Flag update: N=result[WIDTH-1], Z=(result==0). The flag register is written on the same edge result is loaded, only when executed && (s || CMP).
- Latency:
  - Single-cycle ops: accept at edge k, out_valid=1 after edge k.
  - MUL (condition passed): state IDLE->MUL, then WIDTH iterations (one multiplier bit per clock). Result and flags load at edge k+WIDTH, state returns to IDLE. in_ready=0 throughout.
- Output stall: while out_valid && !out_ready, result/executed/flags hold stable and no new op is accepted. out_valid clears on the out_ready edge unless a new op is accepted in the same cycle.

Optional Feature:
- ALU_DIV_EN defined:
  - Opcode 1000 = unsigned DIV a/b', using a restoring divider.
  - New state DIV, WIDTH cycles, same timing as MUL.
  - Flags: C=0. Divide by zero gives result all-ones and V=1; otherwise V=0.
- ALU_DIV_EN undefined: opcode 1000 behaves as an undefined opcode (result=0, 1 cycle). No divider logic is synthesised.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_CMP, OP_DIV);
  - condition-code localparams;
  - the sh_ctl encodings;
  - the state enum (IDLE, MUL, DIV);
  - flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0).
- One sub-module is natural: alu_seq_shifter, a combinational WIDTH-parametrised LSR/LSL/ROR barrel shifter.
- Condition evaluation and the iterative units stay in the top module.

Test Plan:
- Reset with all flags zero; ADD s=1, a=32'h7FFFFFFF, b=1 -> result 32'h80000000, flags N=1 Z=0 C=0 V=1, out_valid one cycle after accept.
- CMP a=5, b=5, s=0, then ADD cond=EQ a=1 b=2 -> flags Z=1 C=1 after CMP; ADD gives result 3, executed=1. Follow with ADD cond=NE -> result 0, executed=0, flags unchanged.
- MUL a=32'hFFFFFFFF, b=3, s=1 -> in_ready low 32 cycles; result 32'hFFFFFFFD, N=1 Z=0 C=0 V=0. Assert rst_n=0 mid-multiply -> out_valid stays 0, flags 0.
- SUB with sh_ctl=LSL, sh_amt=4, a=32'h100, b=32'h10 -> result 0, Z=1, C=1. ROR sh_amt=1 on b=1 with MOV-free AND a=32'h80000000 -> result 32'h80000000.
- Hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0. Release -> back-to-back XOR ops complete one per clock.
- ALU_DIV_EN: DIV 100/7 -> result 14 after 32 cycles. DIV by 0 -> result 32'hFFFFFFFF, V=1. Without the macro, opcode 1000 -> result 0 after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: opcodes, condition codes,
// shift controls, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_MOVI = 4'h6;
    localparam logic [3:0] OP_MOV  = 4'h7;
    localparam logic [3:0] OP_DIV  = 4'h8;
    localparam logic [3:0] OP_CMP  = 4'hB;

    localparam logic [3:0] CC_AL = 4'h0;
    localparam logic [3:0] CC_EQ = 4'h1;
    localparam logic [3:0] CC_NE = 4'h2;
    localparam logic [3:0] CC_GT = 4'h3;
    localparam logic [3:0] CC_LT = 4'h4;
    localparam logic [3:0] CC_GE = 4'h5;
    localparam logic [3:0] CC_LE = 4'h6;
    localparam logic [3:0] CC_HI = 4'h7;
    localparam logic [3:0] CC_LO = 4'h8;
    localparam logic [3:0] CC_HS = 4'h9;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSR  = 2'b01;
    localparam logic [1:0] SH_LSL  = 2'b10;
    localparam logic [1:0] SH_ROR  = 2'b11;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// Combinational operand-B barrel shifter: none / LSR / LSL / ROR.
module alu_seq_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       sh_ctl_i,
    input  logic [SHW-1:0]   sh_amt_i,
    output logic [WIDTH-1:0] data_o
);

    logic [SHW:0] inv_amt;

    // A zero rotate gives a left shift by WIDTH, which clears that term.
    assign inv_amt = (SHW+1)'(WIDTH) - {1'b0, sh_amt_i};

    always_comb begin
        data_o = data_i;
        case (sh_ctl_i)
            SH_LSR:  data_o = data_i >> sh_amt_i;
            SH_LSL:  data_o = data_i << sh_amt_i;
            SH_ROR:  data_o = (data_i >> sh_amt_i) | (data_i << inv_amt);
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with NZCV flags, condition codes and a shift-add multiplier.
// Define ALU_DIV_EN to add a restoring unsigned divider on opcode 1000.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [3:0]         cond,
    input  logic               s,
    input  logic [1:0]         sh_ctl,
    input  logic [SHW-1:0]     sh_amt,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH/2-1:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               executed,
    output logic [3:0]         flags
);

    state_e             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               executed_q, executed_d;
    logic [3:0]         flags_q, flags_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               mset_q, mset_d;

    logic [WIDTH-1:0]   b_sh;
    logic               accept;
    logic               cond_ok;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               alu_def;
    logic [WIDTH-1:0]   mul_sum;

    alu_seq_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data_i   (op_b),
        .sh_ctl_i (sh_ctl),
        .sh_amt_i (sh_amt),
        .data_o   (b_sh)
    );

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign executed  = executed_q;
    assign flags     = flags_q;

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            CC_AL:   cond_ok = 1'b1;
            CC_EQ:   cond_ok = flags_q[FLG_Z];
            CC_NE:   cond_ok = !flags_q[FLG_Z];
            CC_GT:   cond_ok = !flags_q[FLG_Z] &&
                               (flags_q[FLG_N] == flags_q[FLG_V]);
            CC_LT:   cond_ok = flags_q[FLG_N] != flags_q[FLG_V];
            CC_GE:   cond_ok = flags_q[FLG_N] == flags_q[FLG_V];
            CC_LE:   cond_ok = flags_q[FLG_Z] ||
                               (flags_q[FLG_N] != flags_q[FLG_V]);
            CC_HI:   cond_ok = flags_q[FLG_C] && !flags_q[FLG_Z];
            CC_LO:   cond_ok = !flags_q[FLG_C];
            CC_HS:   cond_ok = flags_q[FLG_C];
            default: cond_ok = 1'b0;
        endcase
    end

    always_comb begin
        add_w   = {1'b0, op_a} + {1'b0, b_sh};
        sub_w   = {1'b0, op_a} - {1'b0, b_sh};
        alu_res = '0;
        alu_c   = flags_q[FLG_C];
        alu_v   = flags_q[FLG_V];
        alu_def = 1'b1;
        case (opcode)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (op_a[WIDTH-1] == b_sh[WIDTH-1]) &&
                          (add_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = !sub_w[WIDTH];
                alu_v   = (op_a[WIDTH-1] != b_sh[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_OR:   alu_res = op_a | b_sh;
            OP_AND:  alu_res = op_a & b_sh;
            OP_XOR:  alu_res = op_a ^ b_sh;
            OP_MOVI: alu_res = {{(WIDTH/2){1'b0}}, imm};
            OP_MOV:  alu_res = op_a;
            default: alu_def = 1'b0;
        endcase
    end

    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef ALU_DIV_EN
    logic [WIDTH:0]   div_tmp;
    logic             div_ge;
    logic [WIDTH:0]   div_rem;
    logic [WIDTH-1:0] div_quo;

    // acc holds the partial remainder, mplier shifts dividend out / quotient in.
    always_comb begin
        div_tmp = {acc_q, mplier_q[WIDTH-1]};
        div_ge  = div_tmp >= {1'b0, mcand_q};
        div_rem = div_ge ? (div_tmp - {1'b0, mcand_q}) : div_tmp;
        div_quo = {mplier_q[WIDTH-2:0], div_ge};
    end
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        executed_d  = executed_q;
        flags_d     = flags_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        mset_d      = mset_q;
        unique case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    mset_d   = s;
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = b_sh;
                    cnt_d    = '0;
                    if (!cond_ok) begin
                        out_valid_d = 1'b1;
                        result_d    = '0;
                        executed_d  = 1'b0;
                    end else if (opcode == OP_MUL) begin
                        state_d     = MUL;
                        out_valid_d = 1'b0;
`ifdef ALU_DIV_EN
                    end else if (opcode == OP_DIV) begin
                        state_d     = DIV;
                        out_valid_d = 1'b0;
                        mcand_d     = b_sh;
                        mplier_d    = op_a;
`endif
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        executed_d  = 1'b1;
                        if (alu_def && (s || opcode == OP_CMP)) begin
                            flags_d = {alu_res[WIDTH-1],
                                       alu_res == '0, alu_c, alu_v};
                        end
                    end
                end
            end
            MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_sum;
                    executed_d  = 1'b1;
                    if (mset_q) begin
                        flags_d = {mul_sum[WIDTH-1], mul_sum == '0, 2'b00};
                    end
                end
            end
`ifdef ALU_DIV_EN
            DIV: begin
                acc_d    = div_rem[WIDTH-1:0];
                mplier_d = div_quo;
                cnt_d    = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b1;
                    result_d    = div_quo;
                    executed_d  = 1'b1;
                    if (mset_q) begin
                        flags_d = {div_quo[WIDTH-1], div_quo == '0,
                                   1'b0, mcand_q == '0};
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            executed_q  <= 1'b0;
            flags_q     <= 4'b0000;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            mset_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            executed_q  <= executed_d;
            flags_q     <= flags_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            mset_q      <= mset_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32); honours ALU_DIV_EN.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [3:0]  cond;
    logic        s;
    logic [1:0]  sh_ctl;
    logic [4:0]  sh_amt;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        executed;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .cond      (cond),
        .s         (s),
        .sh_ctl    (sh_ctl),
        .sh_amt    (sh_amt),
        .op_a      (op_a),
        .op_b      (op_b),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .executed  (executed),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] cc,
                         input logic sf, input logic [1:0] shc,
                         input logic [4:0] sha, input logic [31:0] a,
                         input logic [31:0] b);
        in_valid = 1'b1;
        opcode   = op;
        cond     = cc;
        s        = sf;
        sh_ctl   = shc;
        sh_amt   = sha;
        op_a     = a;
        op_b     = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; cond = '0; s = 1'b0; sh_ctl = '0; sh_amt = '0;
        op_a = '0; op_b = '0; imm = '0;
        #22;
        n_cmp++;
        if ({out_valid, executed, flags, result} !== 38'd0) begin
            n_bad++;
            $display("FAIL reset_outs: got v=%b e=%b f=%b r=%h want all 0",
                     out_valid, executed, flags, result);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready: got %b want 1", in_ready);
        end
        @(posedge clk); #1; rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_ovf();
        drive(OP_ADD, CC_AL, 1'b1, SH_NONE, 5'd0, 32'h7FFF_FFFF, 32'h1);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_pre_valid: got %b want 0", out_valid);
        end
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, result, flags} !== {1'b1, 32'h8000_0000, 4'b1001}) begin
            n_bad++;
            $display("FAIL add_ovf: got v=%b r=%h f=%b want v=1 r=80000000 f=1001",
                     out_valid, result, flags);
        end
    endtask

    task automatic test_cond();
        drive(OP_CMP, CC_AL, 1'b0, SH_NONE, 5'd0, 32'd5, 32'd5);
        step();
        n_cmp++;
        if (flags !== 4'b0110) begin
            n_bad++;
            $display("FAIL cmp_flags: got %b want 0110", flags);
        end
        drive(OP_ADD, CC_EQ, 1'b0, SH_NONE, 5'd0, 32'd1, 32'd2);
        step();
        n_cmp++;
        if ({result, executed, flags} !== {32'd3, 1'b1, 4'b0110}) begin
            n_bad++;
            $display("FAIL add_eq: got r=%h e=%b f=%b want r=3 e=1 f=0110",
                     result, executed, flags);
        end
        drive(OP_ADD, CC_NE, 1'b1, SH_NONE, 5'd0, 32'd1, 32'd2);
        step();
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, result, executed, flags} !==
            {1'b1, 32'd0, 1'b0, 4'b0110}) begin
            n_bad++;
            $display("FAIL add_ne: got v=%b r=%h e=%b f=%b want v=1 r=0 e=0 f=0110",
                     out_valid, result, executed, flags);
        end
    endtask

    task automatic test_shift();
        drive(OP_SUB, CC_AL, 1'b1, SH_LSL, 5'd4, 32'h100, 32'h10);
        step();
        n_cmp++;
        if ({result, flags} !== {32'd0, 4'b0110}) begin
            n_bad++;
            $display("FAIL sub_lsl: got r=%h f=%b want r=0 f=0110",
                     result, flags);
        end
        drive(OP_AND, CC_AL, 1'b1, SH_ROR, 5'd1, 32'h8000_0000, 32'h1);
        step();
        n_cmp++;
        if ({result, flags} !== {32'h8000_0000, 4'b1010}) begin
            n_bad++;
            $display("FAIL and_ror: got r=%h f=%b want r=80000000 f=1010",
                     result, flags);
        end
        drive(OP_OR, CC_AL, 1'b0, SH_LSR, 5'd4, 32'h0, 32'hF0);
        step();
        n_cmp++;
        if (result !== 32'h0F) begin
            n_bad++;
            $display("FAIL or_lsr: got %h want 0000000f", result);
        end
        drive(4'hC, CC_AL, 1'b1, SH_NONE, 5'd0, 32'h55, 32'h66);
        step();
        n_cmp++;
        if ({result, executed, flags} !== {32'd0, 1'b1, 4'b1010}) begin
            n_bad++;
            $display("FAIL undef_op: got r=%h e=%b f=%b want r=0 e=1 f=1010",
                     result, executed, flags);
        end
        in_valid = 1'b1; opcode = OP_MOVI; s = 1'b0; imm = 16'hBEEF;
        step();
        in_valid = 1'b0;
        n_cmp++;
        if (result !== 32'h0000_BEEF) begin
            n_bad++;
            $display("FAIL movi: got %h want 0000beef", result);
        end
    endtask

    task automatic test_mul();
        int n;
        int low;
        drive(OP_MUL, CC_EQ, 1'b1, SH_NONE, 5'd0, 32'hFFFF_FFFF, 32'd3);
        step();
        n_cmp++;
        if ({out_valid, result, executed, flags} !==
            {1'b1, 32'd0, 1'b0, 4'b1010}) begin
            n_bad++;
            $display("FAIL mul_condfail: got v=%b r=%h e=%b f=%b want v=1 r=0 e=0 f=1010",
                     out_valid, result, executed, flags);
        end
        drive(OP_MUL, CC_AL, 1'b1, SH_NONE, 5'd0, 32'hFFFF_FFFF, 32'd3);
        step();
        in_valid = 1'b0;
        n = 0;
        low = 0;
        while (!out_valid && n < 100) begin
            if (in_ready === 1'b0) low++;
            step();
            n++;
        end
        n_cmp++;
        if (n != 32 || low != 32) begin
            n_bad++;
            $display("FAIL mul_latency: got %0d cycles (%0d not ready) want 32",
                     n, low);
        end
        n_cmp++;
        if ({result, executed, flags} !== {32'hFFFF_FFFD, 1'b1, 4'b1000}) begin
            n_bad++;
            $display("FAIL mul_res: got r=%h e=%b f=%b want r=fffffffd e=1 f=1000",
                     result, executed, flags);
        end
        drive(OP_MUL, CC_AL, 1'b1, SH_NONE, 5'd0, 32'd7, 32'd9);
        step();
        in_valid = 1'b0;
        repeat (10) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, flags, in_ready} !== {1'b0, 4'b0000, 1'b1}) begin
            n_bad++;
            $display("FAIL mul_abort: got v=%b f=%b rdy=%b want v=0 f=0000 rdy=1",
                     out_valid, flags, in_ready);
        end
        step();
        rst_n = 1'b1;
        n = 0;
        repeat (40) begin
            if (out_valid !== 1'b0) n++;
            step();
        end
        n_cmp++;
        if (n != 0 || flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL mul_abort_quiet: got %0d valid cycles f=%b want 0 f=0000",
                     n, flags);
        end
    endtask

    task automatic test_stall();
        int bad;
        out_ready = 1'b0;
        drive(OP_XOR, CC_AL, 1'b0, SH_NONE, 5'd0, 32'hFF, 32'h0F);
        step();
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'hF0}) begin
            n_bad++;
            $display("FAIL stall_first: got v=%b r=%h want v=1 r=f0",
                     out_valid, result);
        end
        drive(OP_XOR, CC_AL, 1'b0, SH_NONE, 5'd0, 32'h1, 32'h3);
        bad = 0;
        repeat (5) begin
            if (in_ready !== 1'b0 || result !== 32'hF0 || out_valid !== 1'b1)
                bad++;
            step();
        end
        n_cmp++;
        if (bad != 0 || result !== 32'hF0) begin
            n_bad++;
            $display("FAIL stall_hold: got %0d bad cycles r=%h want 0 r=f0",
                     bad, result);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release: got rdy=%b want 1", in_ready);
        end
        step();
        n_cmp++;
        if (result !== 32'h2) begin
            n_bad++;
            $display("FAIL b2b_0: got %h want 2", result);
        end
        drive(OP_XOR, CC_AL, 1'b0, SH_NONE, 5'd0, 32'h55, 32'hFF);
        step();
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'hAA}) begin
            n_bad++;
            $display("FAIL b2b_1: got v=%b r=%h want v=1 r=aa", out_valid, result);
        end
        drive(OP_XOR, CC_AL, 1'b0, SH_NONE, 5'd0, 32'h1234, 32'h1234);
        step();
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'h0}) begin
            n_bad++;
            $display("FAIL b2b_2: got v=%b r=%h want v=1 r=0", out_valid, result);
        end
        in_valid = 1'b0;
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_div();
        int n;
        drive(OP_DIV, CC_AL, 1'b1, SH_NONE, 5'd0, 32'd100, 32'd7);
        step();
        in_valid = 1'b0;
`ifdef ALU_DIV_EN
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 32 || result !== 32'd14 || flags !== 4'b0000) begin
            n_bad++;
            $display("FAIL div_100_7: got %0d cycles r=%h f=%b want 32 r=e f=0000",
                     n, result, flags);
        end
        drive(OP_DIV, CC_AL, 1'b1, SH_NONE, 5'd0, 32'd5, 32'd0);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 32 || result !== 32'hFFFF_FFFF || flags !== 4'b1001) begin
            n_bad++;
            $display("FAIL div_zero: got %0d cycles r=%h f=%b want 32 r=ffffffff f=1001",
                     n, result, flags);
        end
`else
        n = 0;
        n_cmp++;
        if ({out_valid, result, executed, flags} !==
            {1'b1, 32'd0, 1'b1, 4'b0000}) begin
            n_bad++;
            $display("FAIL div_undef: got v=%b r=%h e=%b f=%b want v=1 r=0 e=1 f=0000",
                     out_valid, result, executed, flags);
        end
        n_cmp++;
        if (in_ready !== 1'b1 || n != 0) begin
            n_bad++;
            $display("FAIL div_undef_ready: got %b want 1", in_ready);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_add_ovf();
        test_cond();
        test_shift();
        test_mul();
        test_stall();
        test_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
